pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//   Registered program-counter unit for the MIPS core; successor to the combinational
//   next-PC calculator. Holds PC, computes the next PC and supports:
//   - sequential flow, BEQ/BNE, J/JAL/JR
//   - stall
//   - optional one-instruction branch delay slot
//   Drives the instruction-memory word index; supplies the JAL link address to the register file.
// PARAMETERS
//   ADDR_W     32            PC/address width in bits; legal 18..32; all PC arithmetic is mod 2^ADDR_W
//   IM_AW      10            instruction-memory word-index width; im_addr = pc[IM_AW+1:2]
//   RESET_PC   32'h0000_3000 PC value loaded on reset; truncated to ADDR_W bits
//   DELAY_SLOT 0             0: transfer takes effect next cycle; 1: one delay-slot instruction runs first
// PORTS
//   clk        in   1       rising-edge clock
//   rst        in   1       asynchronous, active-high reset
//   stall      in   1       1: hold PC and FSM; npc_op ignored this cycle
//   npc_op     in   3       000 SEQ, 001 BEQ, 010 BNE, 011 J, 100 JAL, 101 JR; 110/111 decode as SEQ
//   alu_zero   in   1       ALU zero flag for the current branch
//   imm16      in   16      branch offset in words, signed
//   imm26      in   26      jump target field
//   rs_data    in   ADDR_W  JR target register value
//   pc         out  ADDR_W  current PC (registered)
//   im_addr    out  IM_AW   pc[IM_AW+1:2]
//   pc_plus4   out  ADDR_W  pc + 4 (combinational)
//   link_addr  out  ADDR_W  JAL return address: pc+4 if DELAY_SLOT=0, pc+8 if DELAY_SLOT=1
//   redirect   out  1       registered; 1 for the cycle after a committed taken transfer (0 after SEQ/untaken)
//   addr_err   out  1       registered; 1 for one cycle after a committed JR with rs_data[1:0]!=0
// BEHAVIOUR
//   Reset (async, any time, including mid-transfer)
//   - pc=RESET_PC, FSM=IDLE, redirect=0, addr_err=0, pending target cleared.
//   Targets, computed from the current pc
//   - BR = pc_plus4 + (sext(imm16)<<2)
//   - JT = {pc_plus4[31:28], imm26, 2'b00}, truncated to ADDR_W bits
//   - JRT = rs_data with bits [1:0] forced to 0
//   Taken
//   - BEQ: alu_zero=1; BNE: alu_zero=0; J/JAL/JR: always. SEQ never taken.
//   Commit
//   - An op commits on a rising edge with stall=0 and rst=0.
//   - stall=1: pc, FSM, pending target held; redirect and addr_err update to 0.
//   DELAY_SLOT=0
//   - Single state. Next pc = target if taken, else pc_plus4.
//   - Latency: 1 cycle from commit to pc==target.
//   DELAY_SLOT=1 (FSM IDLE/PENDING)
//   - IDLE, taken commit: pend_tgt<=target; pc<=pc_plus4 (delay slot); ->PENDING; redirect<=0.
//   - IDLE, untaken/SEQ: pc<=pc_plus4.
//   - PENDING, commit: pc<=pend_tgt; ->IDLE; redirect<=1.
//     npc_op in the delay slot is ignored (no nested transfer, no addr_err).
//   - PENDING with stall=1: remains PENDING.
//   Wrap-around
//   - pc_plus4 and BR wrap mod 2^ADDR_W; no overflow flag.
//   - Backward branch with imm16=16'hFFFF targets pc itself (self-loop), legal.
//   Other outputs
//   - link_addr is combinational from pc and valid on the JAL cycle.
//   - pc bits [1:0] are always 0 after reset if RESET_PC is word aligned.
// TESTING
//   1 Reset/sequential: rst pulse, 3 SEQ cycles
//     -> pc 0x3000,0x3004,0x3008,0x300C; im_addr 0,1,2,3 (RESET_PC=0x3000).
//   2 BEQ taken/untaken: pc=0x3008, BEQ imm16=0x0024, alu_zero=1
//     -> pc=0x309C, redirect=1; repeat with alu_zero=0 -> pc=0x300C.
//   3 BNE backward: pc=0x3010, BNE imm16=16'hFFFC, alu_zero=0 -> pc=0x3004.
//     imm16=16'hFFFF -> pc=0x3010 (self-loop).
//   4 J/JAL/JR: pc=0x3020, J imm26=0x2 -> pc=0x0000_0008.
//     JAL -> link_addr=0x3024 on JAL cycle.
//     JR rs_data=0x3102 -> pc=0x3100, addr_err=1 for one cycle.
//   5 Stall: assert stall 2 cycles with BEQ taken on npc_op -> pc unchanged, redirect=0.
//     Release stall -> branch commits.
//   6 DELAY_SLOT=1: pc=0x3000, J imm26=0x40 -> next pc=0x3004 (J in slot ignored), then 0x0100;
//     rst asserted while PENDING -> pc=0x3000, FSM IDLE, no later jump to 0x0100.

Source files
------------

// File: rtl/pc_sequencer.sv
// Registered program counter for the MIPS core: sequential flow, BEQ/BNE, J/JAL/JR,
// stall, and an optional single-instruction branch delay slot.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | normal flow; a taken transfer either redirects or (delay slot) arms PENDING
// PENDING | delay-slot instruction is executing; next commit loads pend_tgt
module pc_sequencer #(
    parameter int          ADDR_W     = 32,
    parameter int          IM_AW      = 10,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter int          DELAY_SLOT = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic [2:0]        npc_op,
    input  logic              alu_zero,
    input  logic [15:0]       imm16,
    input  logic [25:0]       imm26,
    input  logic [ADDR_W-1:0] rs_data,
    output logic [ADDR_W-1:0] pc,
    output logic [IM_AW-1:0]  im_addr,
    output logic [ADDR_W-1:0] pc_plus4,
    output logic [ADDR_W-1:0] link_addr,
    output logic              redirect,
    output logic              addr_err
);

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } state_t;

    localparam logic [2:0] OP_SEQ = 3'b000;
    localparam logic [2:0] OP_BEQ = 3'b001;
    localparam logic [2:0] OP_BNE = 3'b010;
    localparam logic [2:0] OP_J   = 3'b011;
    localparam logic [2:0] OP_JAL = 3'b100;
    localparam logic [2:0] OP_JR  = 3'b101;

    localparam logic [ADDR_W-1:0] PC_RST     = RESET_PC[ADDR_W-1:0];
    localparam logic [31:0]       HI_MASK32  = 32'hF000_0000;
    localparam logic [ADDR_W-1:0] HI_MASK    = HI_MASK32[ADDR_W-1:0];

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] pc_nxt;
    logic [ADDR_W-1:0] pend_tgt, pend_tgt_nxt;
    logic              redirect_nxt, addr_err_nxt;

    logic [ADDR_W-1:0] br_off, br_tgt, j_tgt, jr_tgt, target;
    logic [27:0]       j_low;
    logic              taken, is_jr;

    assign pc_plus4  = pc + ADDR_W'(4);
    assign im_addr   = pc[IM_AW+1:2];
    assign link_addr = (DELAY_SLOT != 0) ? pc + ADDR_W'(8) : pc_plus4;

    // Offset is a signed word count; sign-extend after the <<2 so wrap is mod 2^ADDR_W.
    assign br_off = ADDR_W'($signed({imm16, 2'b00}));
    assign br_tgt = pc_plus4 + br_off;
    assign j_low  = {imm26, 2'b00};
    assign j_tgt  = (pc_plus4 & HI_MASK) | ADDR_W'(j_low);
    assign jr_tgt = rs_data & ~ADDR_W'(3);

    always_comb begin
        taken  = 1'b0;
        is_jr  = 1'b0;
        target = pc_plus4;
        case (npc_op)
            OP_BEQ: begin
                taken  = alu_zero;
                target = br_tgt;
            end
            OP_BNE: begin
                taken  = ~alu_zero;
                target = br_tgt;
            end
            OP_J, OP_JAL: begin
                taken  = 1'b1;
                target = j_tgt;
            end
            OP_JR: begin
                taken  = 1'b1;
                is_jr  = 1'b1;
                target = jr_tgt;
            end
            default: begin
                taken  = 1'b0;
                target = pc_plus4;
            end
        endcase
    end

    always_comb begin
        pc_nxt       = pc;
        state_nxt    = state;
        pend_tgt_nxt = pend_tgt;
        redirect_nxt = 1'b0;
        addr_err_nxt = 1'b0;
        if (!stall) begin
            if (state == PENDING) begin
                // Delay-slot op is deliberately ignored: no nested transfers.
                pc_nxt       = pend_tgt;
                state_nxt    = IDLE;
                redirect_nxt = 1'b1;
            end else begin
                addr_err_nxt = is_jr && (rs_data[1:0] != 2'b00);
                if (taken) begin
                    if (DELAY_SLOT != 0) begin
                        pend_tgt_nxt = target;
                        pc_nxt       = pc_plus4;
                        state_nxt    = PENDING;
                    end else begin
                        pc_nxt       = target;
                        redirect_nxt = 1'b1;
                    end
                end else begin
                    pc_nxt = pc_plus4;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= PC_RST;
            state    <= IDLE;
            pend_tgt <= '0;
            redirect <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            state    <= state_nxt;
            pend_tgt <= pend_tgt_nxt;
            redirect <= redirect_nxt;
            addr_err <= addr_err_nxt;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: one instance without and one with the delay slot,
// sharing stimulus but reset independently.
module tb_pc_sequencer;

    localparam logic [2:0] SEQ = 3'b000;
    localparam logic [2:0] BEQ = 3'b001;
    localparam logic [2:0] BNE = 3'b010;
    localparam logic [2:0] J   = 3'b011;
    localparam logic [2:0] JAL = 3'b100;
    localparam logic [2:0] JR  = 3'b101;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_ds = 1'b1;
    logic        stall = 1'b0;
    logic [2:0]  npc_op = SEQ;
    logic        alu_zero = 1'b0;
    logic [15:0] imm16 = '0;
    logic [25:0] imm26 = '0;
    logic [31:0] rs_data = '0;

    logic [31:0] pc, pc_plus4, link_addr;
    logic [9:0]  im_addr;
    logic        redirect, addr_err;

    logic [31:0] pc_ds, pc_plus4_ds, link_addr_ds;
    logic [9:0]  im_addr_ds;
    logic        redirect_ds, addr_err_ds;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.DELAY_SLOT(0)) dut (
        .clk(clk), .rst(rst), .stall(stall), .npc_op(npc_op), .alu_zero(alu_zero),
        .imm16(imm16), .imm26(imm26), .rs_data(rs_data),
        .pc(pc), .im_addr(im_addr), .pc_plus4(pc_plus4), .link_addr(link_addr),
        .redirect(redirect), .addr_err(addr_err)
    );

    pc_sequencer #(.DELAY_SLOT(1)) dut_ds (
        .clk(clk), .rst(rst_ds), .stall(stall), .npc_op(npc_op), .alu_zero(alu_zero),
        .imm16(imm16), .imm26(imm26), .rs_data(rs_data),
        .pc(pc_ds), .im_addr(im_addr_ds), .pc_plus4(pc_plus4_ds), .link_addr(link_addr_ds),
        .redirect(redirect_ds), .addr_err(addr_err_ds)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Moves the DS=0 instance to an arbitrary aligned pc with a JR.
    task automatic set_pc(input logic [31:0] addr);
        npc_op  = JR;
        rs_data = addr;
        step();
        npc_op  = SEQ;
    endtask

    task automatic test_reset();
        #12;
        total++; if (pc !== 32'h3000) begin bad++; $display("FAIL reset_pc got %h exp %h", pc, 32'h3000); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL reset_redirect got %b exp 0", redirect); end
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL reset_addr_err got %b exp 0", addr_err); end
        total++; if (pc_plus4 !== 32'h3004) begin bad++; $display("FAIL reset_pc_plus4 got %h exp %h", pc_plus4, 32'h3004); end
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_seq();
        logic [31:0] exp_pc [4] = '{32'h3000, 32'h3004, 32'h3008, 32'h300C};
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            total++; if (pc !== exp_pc[i]) begin bad++; $display("FAIL seq_pc[%0d] got %h exp %h", i, pc, exp_pc[i]); end
            total++; if (im_addr !== 10'(i)) begin bad++; $display("FAIL seq_im_addr[%0d] got %0d exp %0d", i, im_addr, i); end
        end
    endtask

    task automatic test_beq();
        set_pc(32'h3008);
        npc_op = BEQ; imm16 = 16'h0024; alu_zero = 1'b1;
        step();
        total++; if (pc !== 32'h309C) begin bad++; $display("FAIL beq_taken_pc got %h exp %h", pc, 32'h309C); end
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL beq_taken_redirect got %b exp 1", redirect); end
        set_pc(32'h3008);
        npc_op = BEQ; alu_zero = 1'b0;
        step();
        total++; if (pc !== 32'h300C) begin bad++; $display("FAIL beq_untaken_pc got %h exp %h", pc, 32'h300C); end
        total++; if (redirect !== 1'b0) begin bad++; $display("FAIL beq_untaken_redirect got %b exp 0", redirect); end
    endtask

    task automatic test_bne();
        set_pc(32'h3010);
        npc_op = BNE; imm16 = 16'hFFFC; alu_zero = 1'b0;
        step();
        total++; if (pc !== 32'h3004) begin bad++; $display("FAIL bne_back_pc got %h exp %h", pc, 32'h3004); end
        set_pc(32'h3010);
        npc_op = BNE; imm16 = 16'hFFFF; alu_zero = 1'b0;
        step();
        total++; if (pc !== 32'h3010) begin bad++; $display("FAIL bne_selfloop_pc got %h exp %h", pc, 32'h3010); end
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL bne_selfloop_redirect got %b exp 1", redirect); end
        npc_op = BNE; alu_zero = 1'b1;
        step();
        total++; if (pc !== 32'h3014) begin bad++; $display("FAIL bne_untaken_pc got %h exp %h", pc, 32'h3014); end
    endtask

    task automatic test_jumps();
        set_pc(32'h3020);
        npc_op = J; imm26 = 26'h2;
        step();
        total++; if (pc !== 32'h0000_0008) begin bad++; $display("FAIL j_pc got %h exp %h", pc, 32'h8); end
        set_pc(32'h3020);
        npc_op = JAL; imm26 = 26'h2;
        #1;
        total++; if (link_addr !== 32'h3024) begin bad++; $display("FAIL jal_link got %h exp %h", link_addr, 32'h3024); end
        step();
        total++; if (pc !== 32'h0000_0008) begin bad++; $display("FAIL jal_pc got %h exp %h", pc, 32'h8); end
        npc_op = JR; rs_data = 32'h3102;
        step();
        total++; if (pc !== 32'h3100) begin bad++; $display("FAIL jr_pc got %h exp %h", pc, 32'h3100); end
        total++; if (addr_err !== 1'b1) begin bad++; $display("FAIL jr_addr_err got %b exp 1", addr_err); end
        npc_op = SEQ;
        step();
        total++; if (addr_err !== 1'b0) begin bad++; $display("FAIL jr_addr_err_clear got %b exp 0", addr_err); end
        total++; if (pc !== 32'h3104) begin bad++; $display("FAIL jr_next_pc got %h exp %h", pc, 32'h3104); end
    endtask

    task automatic test_stall();
        set_pc(32'h3008);
        stall = 1'b1; npc_op = BEQ; imm16 = 16'h0024; alu_zero = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            total++; if (pc !== 32'h3008) begin bad++; $display("FAIL stall_pc[%0d] got %h exp %h", i, pc, 32'h3008); end
            total++; if (redirect !== 1'b0) begin bad++; $display("FAIL stall_redirect[%0d] got %b exp 0", i, redirect); end
        end
        stall = 1'b0;
        step();
        total++; if (pc !== 32'h309C) begin bad++; $display("FAIL stall_release_pc got %h exp %h", pc, 32'h309C); end
        total++; if (redirect !== 1'b1) begin bad++; $display("FAIL stall_release_redirect got %b exp 1", redirect); end
        npc_op = SEQ;
    endtask

    task automatic test_wrap();
        set_pc(32'hFFFF_FFFC);
        total++; if (pc_plus4 !== 32'h0) begin bad++; $display("FAIL wrap_pc_plus4 got %h exp 0", pc_plus4); end
        step();
        total++; if (pc !== 32'h0) begin bad++; $display("FAIL wrap_pc got %h exp 0", pc); end
    endtask

    task automatic test_delay_slot();
        npc_op = SEQ;
        #1;
        total++; if (pc_ds !== 32'h3000) begin bad++; $display("FAIL ds_reset_pc got %h exp %h", pc_ds, 32'h3000); end
        rst_ds = 1'b0;
        npc_op = J; imm26 = 26'h40;
        step();
        total++; if (pc_ds !== 32'h3004) begin bad++; $display("FAIL ds_slot_pc got %h exp %h", pc_ds, 32'h3004); end
        total++; if (redirect_ds !== 1'b0) begin bad++; $display("FAIL ds_slot_redirect got %b exp 0", redirect_ds); end
        npc_op = J; imm26 = 26'h80;
        step();
        total++; if (pc_ds !== 32'h0100) begin bad++; $display("FAIL ds_target_pc got %h exp %h", pc_ds, 32'h100); end
        total++; if (redirect_ds !== 1'b1) begin bad++; $display("FAIL ds_target_redirect got %b exp 1", redirect_ds); end
        total++; if (link_addr_ds !== 32'h0108) begin bad++; $display("FAIL ds_link got %h exp %h", link_addr_ds, 32'h108); end
        npc_op = J; imm26 = 26'h40;
        step();
        stall = 1'b1; npc_op = SEQ;
        step();
        total++; if (pc_ds !== 32'h0104) begin bad++; $display("FAIL ds_stall_pc got %h exp %h", pc_ds, 32'h104); end
        stall = 1'b0;
        step();
        total++; if (pc_ds !== 32'h0100) begin bad++; $display("FAIL ds_stall_release_pc got %h exp %h", pc_ds, 32'h100); end
        npc_op = J; imm26 = 26'h40;
        step();
        rst_ds = 1'b1;
        #1;
        total++; if (pc_ds !== 32'h3000) begin bad++; $display("FAIL ds_rst_pending_pc got %h exp %h", pc_ds, 32'h3000); end
        rst_ds = 1'b0;
        npc_op = SEQ;
        step();
        total++; if (pc_ds !== 32'h3004) begin bad++; $display("FAIL ds_after_rst_pc0 got %h exp %h", pc_ds, 32'h3004); end
        step();
        total++; if (pc_ds !== 32'h3008) begin bad++; $display("FAIL ds_after_rst_pc1 got %h exp %h", pc_ds, 32'h3008); end
        total++; if (redirect_ds !== 1'b0) begin bad++; $display("FAIL ds_after_rst_redirect got %b exp 0", redirect_ds); end
    endtask

    initial begin
        test_reset();
        test_seq();
        test_beq();
        test_bne();
        test_jumps();
        test_stall();
        test_wrap();
        test_delay_slot();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
